alu_serial_port: RTL and testbench
==================================

// Module: alu_serial_port
// PURPOSE
//  Initiator side of the bit-serial ALU operand interface. Accepts a parallel operation
//  request (two operand words), drives op_valid and shifts operands out NSHIFT bits per
//  cycle, LSB first, on alu_data_in1/2. Reassembles alu_data_out into a parallel result
//  word and ends on alu_op_done. Sits between the sequencer/memory interface and the ALU.
// PARAMETERS
//  REG_BITS  8   bits per register; single-length op length
//  NSHIFT    2   bits transferred per active cycle
//  WORD_BITS 16  = 2*REG_BITS; pair-op length and width of operand/result words
// PORTS
//  clk            in   1            clock
//  rst_n          in   1            asynchronous active-low reset
//  start          in   1            request pulse; accepted only when !busy
//  pair           in   1            1: WORD_BITS-bit op, 0: REG_BITS-bit op (sampled at start)
//  arg1_word      in   WORD_BITS    operand for alu_data_in1 (sampled at start)
//  arg2_word      in   WORD_BITS    operand for alu_data_in2 (sampled at start)
//  busy           out  1            request in flight (RUN state)
//  result_valid   out  1            one-cycle pulse: result_word/err valid
//  result_word    out  WORD_BITS    reassembled ALU output
//  err            out  1            qualified by result_valid: no op_done before limit
//  alu_op_valid   out  1            to ALU op_valid; ALU shifts every cycle this is high
//  alu_op_done    in   1            from ALU; last cycle of op
//  alu_data_in1   out  NSHIFT       serial operand 1
//  alu_data_in2   out  NSHIFT       serial operand 2
//  alu_data_out   in   NSHIFT       serial result from ALU
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; busy=0, result_valid=0, err=0, alu_op_valid=0,
//    result_word=0, alu_data_in1/2=0, count=0. Reset mid-op drops alu_op_valid at once.
//  - States: IDLE -> RUN on accepted start; RUN -> DONE on alu_op_done or limit;
//    DONE -> RUN on start in that same cycle, else -> IDLE. DONE lasts exactly one cycle.
//  - start accepted in IDLE and DONE (back-to-back allowed); ignored in RUN, no side effect.
//  - On accept: sr1<=arg1_word, sr2<=arg2_word, result_word<=0, count<=0, len<=pair.
//  - RUN: alu_op_valid=1, busy=1. alu_data_inN = srN[NSHIFT-1:0] (combinational from regs).
//    Each RUN cycle: srN >>= NSHIFT (zero fill); result_word[count*NSHIFT +: NSHIFT] <=
//    alu_data_out; count <= count+1.
//  - limit = WORD_BITS/NSHIFT cycles if len else REG_BITS/NSHIFT. RUN ends after the cycle
//    where alu_op_done=1 (err=0) or count reaches limit-1 without it (err=1). Both in same
//    cycle: err=0. Early op_done (timed rotate/ror1) legal: uncollected bits stay 0.
//  - 8-bit op: result in result_word[REG_BITS-1:0], upper bits 0.
//  - DONE: result_valid=1, alu_op_valid=0, busy=0; result_word/err hold until next accept.
//  - alu_op_done outside RUN is ignored. count never exceeds limit-1 (no wrap).
//  - Latency: start in cycle 0 -> op_valid cycles 1..N -> result_valid cycle N+1
//    (N = 4 for 8-bit, 8 for 16-bit at defaults).
//  - alu_op_valid and operands stable from first RUN cycle until op_done, per ALU contract.
// TESTING
//  1. pair=0, arg1=0x00A5, ALU loopback (data_out=data_in1), op_done on 4th cycle ->
//     data_in1 seq 01,01,10,10; result_valid cycle 5, result_word=0x00A5, err=0.
//  2. pair=1, arg2=0xBEEF, loopback data_in2, op_done on 8th cycle -> result_word=0xBEEF
//     at cycle 9; op_valid high cycles 1..8 exactly.
//  3. pair=1, op_done never asserted -> op_valid 8 cycles, result_valid with err=1;
//     repeat with op_done on 8th cycle -> err=0.
//  4. Back-to-back: start held high in DONE -> op_valid low exactly one cycle, second
//     result correct; start during RUN -> ignored, first result unchanged.
//  5. pair=1, op_done on 3rd cycle, data_out=11 -> result_word=0x003F, err=0.
//  6. rst_n low in 2nd RUN cycle -> op_valid/busy 0 immediately, no result_valid; next
//     request after release completes normally.

Source files
------------

// File: rtl/alu_serial_port.sv
// alu_serial_port: initiator side of the bit-serial ALU operand interface.
// Latches two operand words on an accepted start, shifts them out NSHIFT bits
// per cycle (LSB first) while alu_op_valid is high, collects the serial result
// into result_word, and reports completion (or a missing op_done) with a
// one-cycle result_valid pulse.
module alu_serial_port #(
    parameter int REG_BITS  = 8,
    parameter int NSHIFT    = 2,
    parameter int WORD_BITS = 2 * REG_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 pair,
    input  logic [WORD_BITS-1:0] arg1_word,
    input  logic [WORD_BITS-1:0] arg2_word,
    output logic                 busy,
    output logic                 result_valid,
    output logic [WORD_BITS-1:0] result_word,
    output logic                 err,
    output logic                 alu_op_valid,
    input  logic                 alu_op_done,
    output logic [NSHIFT-1:0]    alu_data_in1,
    output logic [NSHIFT-1:0]    alu_data_in2,
    input  logic [NSHIFT-1:0]    alu_data_out
);

    // Beats needed for a pair op; a single-length op uses the low half.
    localparam int MAX_BEATS    = WORD_BITS / NSHIFT;
    localparam int SINGLE_BEATS = REG_BITS / NSHIFT;
    localparam int CNT_W        = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;

    localparam logic [CNT_W-1:0] LAST_PAIR   = CNT_W'(MAX_BEATS - 1);
    localparam logic [CNT_W-1:0] LAST_SINGLE = CNT_W'(SINGLE_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_BITS-1:0] sr1_q, sr1_d;
    logic [WORD_BITS-1:0] sr2_q, sr2_d;
    logic [WORD_BITS-1:0] result_q, result_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 len_q, len_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 op_valid_q, op_valid_d;
    logic                 rvalid_q, rvalid_d;

    logic [CNT_W-1:0]     last_beat;
    logic                 run_end;

    // Next-state, operand shifting and result collection.
    always_comb begin
        state_d   = state_q;
        sr1_d     = sr1_q;
        sr2_d     = sr2_q;
        result_d  = result_q;
        count_d   = count_q;
        len_d     = len_q;
        err_d     = err_q;
        last_beat = len_q ? LAST_PAIR : LAST_SINGLE;
        run_end   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Accept: load operands, clear the result, restart the beat count.
                    state_d  = S_RUN;
                    sr1_d    = arg1_word;
                    sr2_d    = arg2_word;
                    result_d = '0;
                    count_d  = '0;
                    len_d    = pair;
                    err_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sr1_d = sr1_q >> NSHIFT;
                sr2_d = sr2_q >> NSHIFT;
                for (int i = 0; i < MAX_BEATS; i++) begin
                    if (count_q == CNT_W'(i)) begin
                        result_d[i*NSHIFT +: NSHIFT] = alu_data_out;
                    end
                end
                // op_done wins over the limit when both land in the same beat.
                run_end = alu_op_done || (count_q == last_beat);
                if (run_end) begin
                    state_d = S_DONE;
                    err_d   = ~alu_op_done;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d     = (state_d == S_RUN);
        op_valid_d = (state_d == S_RUN);
        rvalid_d   = (state_d == S_DONE);
    end

    // State and registered outputs; reset drops op_valid immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sr1_q      <= '0;
            sr2_q      <= '0;
            result_q   <= '0;
            count_q    <= '0;
            len_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            op_valid_q <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr1_q      <= sr1_d;
            sr2_q      <= sr2_d;
            result_q   <= result_d;
            count_q    <= count_d;
            len_q      <= len_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            op_valid_q <= op_valid_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // Serial operands come straight from the shift registers while running.
    assign alu_data_in1 = op_valid_q ? sr1_q[NSHIFT-1:0] : '0;
    assign alu_data_in2 = op_valid_q ? sr2_q[NSHIFT-1:0] : '0;

    assign busy         = busy_q;
    assign alu_op_valid = op_valid_q;
    assign result_valid = rvalid_q;
    assign result_word  = result_q;
    assign err          = err_q;

endmodule

// File: tb/tb_alu_serial_port.sv
// tb_alu_serial_port: scoreboard bench for alu_serial_port with a behavioural
// ALU responder (loopback of operand 1, operand 2, or a constant) and
// randomized requests.
module tb_alu_serial_port;

    localparam int RB = 8;
    localparam int NS = 2;
    localparam int WB = 16;

    typedef struct {
        logic [WB-1:0] a1;
        logic [WB-1:0] a2;
        int            mode;   // 0: echo in1, 1: echo in2, 2: constant c
        int            dk;     // beat (1-based) on which op_done is raised; out of range = never
        logic [NS-1:0] c;
        int            n;      // beats op_valid must stay high
    } op_t;

    typedef struct {
        logic [WB-1:0] res;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          pair = 1'b0;
    logic [WB-1:0] arg1_word = '0;
    logic [WB-1:0] arg2_word = '0;
    logic          busy;
    logic          result_valid;
    logic [WB-1:0] result_word;
    logic          err;
    logic          alu_op_valid;
    logic          alu_op_done = 1'b0;
    logic [NS-1:0] alu_data_in1;
    logic [NS-1:0] alu_data_in2;
    logic [NS-1:0] alu_data_out = '0;

    int   n_checks = 0;
    int   n_pass   = 0;
    op_t  op_q[$];
    exp_t exp_q[$];

    alu_serial_port #(.REG_BITS(RB), .NSHIFT(NS), .WORD_BITS(WB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pair         (pair),
        .arg1_word    (arg1_word),
        .arg2_word    (arg2_word),
        .busy         (busy),
        .result_valid (result_valid),
        .result_word  (result_word),
        .err          (err),
        .alu_op_valid (alu_op_valid),
        .alu_op_done  (alu_op_done),
        .alu_data_in1 (alu_data_in1),
        .alu_data_in2 (alu_data_in2),
        .alu_data_out (alu_data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, got, want, $time);
        else n_pass++;
    endtask

    // Reference: the op collects min(op_done beat, limit) chunks, each the
    // value the ALU returns on that beat, placed LSB first.
    function automatic void build(input bit p, input op_t oi, output op_t o, output exp_t e);
        int lim;
        logic [WB-1:0] chunk;
        lim   = p ? WB / NS : RB / NS;
        o     = oi;
        e.res = '0;
        if (oi.dk >= 1 && oi.dk <= lim) begin
            o.n   = oi.dk;
            e.err = 1'b0;
        end else begin
            o.n   = lim;
            e.err = 1'b1;
        end
        for (int j = 0; j < o.n; j++) begin
            case (oi.mode)
                0:       chunk = (oi.a1 >> (NS * j)) & WB'(3);
                1:       chunk = (oi.a2 >> (NS * j)) & WB'(3);
                default: chunk = WB'(oi.c);
            endcase
            e.res = e.res | (chunk << (NS * j));
        end
    endfunction

    // Called at a negedge; returns at the negedge of the first RUN cycle.
    task automatic issue(input bit p, input logic [WB-1:0] a1, input logic [WB-1:0] a2,
                         input int mode, input int dk, input logic [NS-1:0] c, output exp_t e);
        op_t oi;
        op_t o;
        oi.a1 = a1; oi.a2 = a2; oi.mode = mode; oi.dk = dk; oi.c = c; oi.n = 0;
        build(p, oi, o, e);
        op_q.push_back(o);
        exp_q.push_back(e);
        pair      = p;
        arg1_word = a1;
        arg2_word = a2;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        arg1_word = WB'($urandom);
        arg2_word = WB'($urandom);
        pair      = 1'($urandom);
    endtask

    // Waits (bounded) for the negedge where result_valid is high.
    task automatic wait_result(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("result_timeout", {31'd0, ok}, 32'd1);
    endtask

    // Full request with a hold check on the cycle after result_valid.
    task automatic run_op(input bit p, input logic [WB-1:0] a1, input logic [WB-1:0] a2,
                          input int mode, input int dk, input logic [NS-1:0] c);
        exp_t e;
        bit   ok;
        issue(p, a1, a2, mode, dk, c, e);
        wait_result(ok);
        @(negedge clk);
        chk("hold_result", {16'd0, result_word}, {16'd0, e.res});
        chk("hold_err", {31'd0, err}, {31'd0, e.err});
        chk("hold_rvalid", {31'd0, result_valid}, 32'd0);
    endtask

    // Behavioural ALU: follows op_valid, checks the serial operands, returns data.
    op_t cur;
    int  cyc = 0;
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            cyc          = 0;
            alu_op_done  = 1'b0;
            alu_data_out = '0;
        end else if (alu_op_valid === 1'b1) begin
            if (cyc == 0) begin
                if (op_q.size() == 0) begin
                    chk("op_valid_unexpected", 32'd1, 32'd0);
                    cur.a1 = '0; cur.a2 = '0; cur.mode = 2; cur.dk = 0; cur.c = '0; cur.n = 0;
                end else begin
                    cur = op_q.pop_front();
                end
            end
            cyc++;
            chk("data_in1", {30'd0, alu_data_in1}, (32'(cur.a1) >> (NS * (cyc - 1))) & 32'd3);
            chk("data_in2", {30'd0, alu_data_in2}, (32'(cur.a2) >> (NS * (cyc - 1))) & 32'd3);
            case (cur.mode)
                0:       alu_data_out = alu_data_in1;
                1:       alu_data_out = alu_data_in2;
                default: alu_data_out = cur.c;
            endcase
            alu_op_done = (cyc == cur.dk);
        end else begin
            if (cyc > 0) begin
                chk("op_valid_len", 32'(cyc), 32'(cur.n));
                cyc = 0;
            end
            // Noise outside an op must be ignored by the DUT.
            alu_op_done  = 1'($urandom);
            alu_data_out = NS'($urandom);
        end
    end

    // Scoreboard monitor: every result_valid pulse consumes one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("result_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result_word", {16'd0, result_word}, {16'd0, e.res});
                chk("result_err", {31'd0, err}, {31'd0, e.err});
                chk("done_busy", {31'd0, busy}, 32'd0);
                chk("done_op_valid", {31'd0, alu_op_valid}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   ok;
        bit   b2b;
        int   lim;
        bit   p;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rvalid", {31'd0, result_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_op_valid", {31'd0, alu_op_valid}, 32'd0);
        chk("rst_result", {16'd0, result_word}, 32'd0);
        chk("rst_data_in", {28'd0, alu_data_in1, alu_data_in2}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 8-bit loopback of operand 1, op_done on beat 4
        run_op(1'b0, 16'h00A5, 16'h1234, 0, 4, 2'd0);
        // 16-bit loopback of operand 2, op_done on beat 8
        run_op(1'b1, 16'h5555, 16'hBEEF, 1, 8, 2'd0);
        // 16-bit without op_done, then with it on the last beat
        run_op(1'b1, 16'hC3A1, 16'h0F0F, 0, 0, 2'd0);
        run_op(1'b1, 16'hC3A1, 16'h0F0F, 0, 8, 2'd0);
        // Early op_done on beat 3 with constant data 11
        run_op(1'b1, 16'hFFFF, 16'hFFFF, 2, 3, 2'd3);

        // Back-to-back: start asserted in DONE
        issue(1'b0, 16'h0096, 16'h0000, 0, 4, 2'd0, e);
        wait_result(ok);
        issue(1'b1, 16'h1357, 16'h2468, 1, 8, 2'd0, e);
        chk("b2b_gap", {31'd0, alu_op_valid}, 32'd1);
        wait_result(ok);
        @(negedge clk);

        // start during RUN is ignored
        issue(1'b1, 16'hA1B2, 16'hC3D4, 0, 8, 2'd0, e);
        arg1_word = 16'hFFFF;
        arg2_word = 16'hFFFF;
        pair      = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        wait_result(ok);
        @(negedge clk);
        chk("ignored_start_idle", {31'd0, busy}, 32'd0);
        chk("ignored_start_hold", {16'd0, result_word}, 32'h0000A1B2);

        // Reset during the second RUN cycle
        issue(1'b1, 16'h7E7E, 16'h8181, 0, 0, 2'd0, e);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_op_valid", {31'd0, alu_op_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        op_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_result", {31'd0, result_valid}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 16'h003C, 16'h00C3, 1, 4, 2'd0);

        // Randomized requests, some back-to-back
        b2b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            p   = 1'($urandom);
            lim = p ? WB / NS : RB / NS;
            issue(p, WB'($urandom), WB'($urandom), $urandom_range(0, 2),
                  $urandom_range(0, lim + 1), NS'($urandom), e);
            if (b2b) chk("b2b_gap_rand", {31'd0, alu_op_valid}, 32'd1);
            wait_result(ok);
            b2b = ok && ($urandom_range(0, 2) == 0) && (i < 39);
            if (!b2b) begin
                @(negedge clk);
                chk("hold_result_rand", {16'd0, result_word}, {16'd0, e.res});
                chk("hold_err_rand", {31'd0, err}, {31'd0, e.err});
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
